seq_detector_prog: RTL and testbench

//  Programmable serial pattern detector; successor of the fixed 2-bit-select sequence_detector.

---
 rtl/seq_detector_prog.sv | 101 ++++++++++
 tb/tb_seq_detector_prog.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/seq_detector_prog.sv
// rtl/seq_detector_prog.sv - programmable serial pattern detector with qualifier, overlap control and saturating match counter
module seq_detector_prog #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 16,
    localparam int LEN_W  = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    input  logic               in_bit,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               clear_count,
    output logic               seq_detected,
    output logic [CNT_W-1:0]   dseq_count,
    output logic               cfg_err,
    output logic [LEN_W-1:0]   hist_fill
);

    localparam logic [LEN_W-1:0] FILL_MAX = LEN_W'(MAX_LEN);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    logic [MAX_LEN-1:0] r_pattern;
    logic [LEN_W-1:0]   r_len;
    logic               r_overlap;
    logic [MAX_LEN-1:0] r_hist;
    logic [LEN_W-1:0]   r_fill;
    logic               r_det;
    logic [CNT_W-1:0]   r_count;
    logic               r_err;

    logic               w_len_ok;
    logic [MAX_LEN-1:0] w_hist_next;
    logic [LEN_W-1:0]   w_fill_next;
    logic [MAX_LEN-1:0] w_mask;
    logic               w_shift;
    logic               w_match;

    assign w_len_ok    = (cfg_len != '0) && (cfg_len <= FILL_MAX);
    assign w_shift     = in_valid && !cfg_load;
    assign w_hist_next = {r_hist[MAX_LEN-2:0], in_bit};
    assign w_fill_next = (r_fill == FILL_MAX) ? FILL_MAX : r_fill + LEN_W'(1);

    // Only the low len bits of history/pattern take part in the compare.
    always_comb begin
        w_mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            w_mask[i] = (i < int'(r_len));
        end
    end

    assign w_match = w_shift && (w_fill_next >= r_len) &&
                     ((w_hist_next & w_mask) == (r_pattern & w_mask));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pattern <= '0;
            r_len     <= LEN_W'(2);
            r_overlap <= 1'b1;
            r_hist    <= '0;
            r_fill    <= '0;
            r_det     <= 1'b0;
            r_count   <= '0;
            r_err     <= 1'b0;
        end else begin
            r_det <= w_match;
            r_err <= cfg_load && !w_len_ok;

            if (cfg_load) begin
                if (w_len_ok) begin
                    r_pattern <= cfg_pattern;
                    r_len     <= cfg_len;
                    r_overlap <= cfg_overlap;
                    r_fill    <= '0;
                end
            end else if (in_valid) begin
                r_hist <= w_hist_next;
                // Non-overlap mode restarts the fill so the next match needs len fresh bits.
                if (w_match && !r_overlap) begin
                    r_fill <= '0;
                end else begin
                    r_fill <= w_fill_next;
                end
            end

            if (clear_count) begin
                r_count <= w_match ? CNT_W'(1) : '0;
            end else if (w_match && (r_count != CNT_MAX)) begin
                r_count <= r_count + CNT_W'(1);
            end
        end
    end

    assign seq_detected = r_det;
    assign dseq_count   = r_count;
    assign cfg_err      = r_err;
    assign hist_fill    = r_fill;

endmodule

// File: tb/tb_seq_detector_prog.sv
// tb/tb_seq_detector_prog.sv - scoreboard bench for seq_detector_prog
module tb_seq_detector_prog;

    localparam int MAX_LEN = 8;
    localparam int LEN_W   = 4;

    logic               clk = 1'b0;
    logic               reset;
    logic               in_valid, in_bit, cfg_load, cfg_overlap, clear_count;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               seq_detected, cfg_err;
    logic [15:0]        dseq_count;
    logic [LEN_W-1:0]   hist_fill;

    logic               b_in_valid, b_in_bit, b_cfg_load, b_cfg_overlap, b_clear;
    logic [MAX_LEN-1:0] b_cfg_pattern;
    logic [LEN_W-1:0]   b_cfg_len;
    logic               b_det, b_err;
    logic [3:0]         b_count;
    logic [LEN_W-1:0]   b_fill;

    seq_detector_prog #(.MAX_LEN(8), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_bit(in_bit),
        .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
        .cfg_overlap(cfg_overlap), .clear_count(clear_count),
        .seq_detected(seq_detected), .dseq_count(dseq_count),
        .cfg_err(cfg_err), .hist_fill(hist_fill)
    );

    seq_detector_prog #(.MAX_LEN(8), .CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .in_valid(b_in_valid), .in_bit(b_in_bit),
        .cfg_load(b_cfg_load), .cfg_pattern(b_cfg_pattern), .cfg_len(b_cfg_len),
        .cfg_overlap(b_cfg_overlap), .clear_count(b_clear),
        .seq_detected(b_det), .dseq_count(b_count),
        .cfg_err(b_err), .hist_fill(b_fill)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        int cnt;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Monitor: every pulse must match the head of the expectation queue.
    always @(negedge clk) begin
        if (!reset && seq_detected) begin
            if (q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_pulse: pulse at cycle %0d count %0d, none expected", cyc, dseq_count);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("pulse_cycle", cyc, e.cyc);
                chk("pulse_count", int'(dseq_count), e.cnt);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic b, input bit m, input int cnt);
        exp_t e;
        in_valid = 1'b1;
        in_bit   = b;
        if (m) begin
            e.cyc = cyc + 1;
            e.cnt = cnt;
            q.push_back(e);
        end
        tick();
        in_valid    = 1'b0;
        clear_count = 1'b0;
    endtask

    task automatic load(input logic [7:0] p, input logic [3:0] l, input logic o);
        cfg_load    = 1'b1;
        cfg_pattern = p;
        cfg_len     = l;
        cfg_overlap = o;
        tick();
        cfg_load = 1'b0;
    endtask

    task automatic clr();
        clear_count = 1'b1;
        tick();
        clear_count = 1'b0;
    endtask

    task automatic send_t1(input bit gaps);
        logic [6:0] s;
        s = 7'b1011011;
        for (int i = 0; i < 7; i++) begin
            if (gaps) repeat (i % 4) tick();
            send(s[6-i], (i == 3) || (i == 6), (i == 3) ? 1 : 2);
        end
    endtask

    initial begin
        reset = 1'b1; in_valid = 0; in_bit = 0; cfg_load = 0; cfg_overlap = 0;
        clear_count = 0; cfg_pattern = '0; cfg_len = '0;
        b_in_valid = 0; b_in_bit = 0; b_cfg_load = 0; b_cfg_overlap = 0;
        b_clear = 0; b_cfg_pattern = '0; b_cfg_len = '0;
        tick(); tick();
        reset = 1'b0;
        chk("rst_det", int'(seq_detected), 0);
        chk("rst_count", int'(dseq_count), 0);
        chk("rst_err", int'(cfg_err), 0);
        chk("rst_fill", int'(hist_fill), 0);

        // Reset default config detects "00".
        send(1'b0, 0, 0);
        send(1'b0, 1, 1);
        tick();
        chk("dflt_count", int'(dseq_count), 1);
        clr();
        chk("clr_count", int'(dseq_count), 0);

        // T1 overlapping 1011
        load(8'b00001011, 4'd4, 1'b1);
        chk("t1_fill_after_load", int'(hist_fill), 0);
        chk("t1_err", int'(cfg_err), 0);
        send_t1(0);
        tick();
        chk("t1_count", int'(dseq_count), 2);
        chk("t1_fill", int'(hist_fill), 7);

        // T2 non-overlapping
        clr();
        load(8'b00001011, 4'd4, 1'b0);
        send(1, 0, 0); send(0, 0, 0); send(1, 0, 0); send(1, 1, 1);
        send(0, 0, 0); send(1, 0, 0); send(1, 0, 0);
        tick();
        chk("t2_count", int'(dseq_count), 1);
        chk("t2_fill", int'(hist_fill), 3);

        // T3 idle gaps between valid bits
        clr();
        load(8'b00001011, 4'd4, 1'b1);
        send_t1(1);
        tick(); tick();
        chk("t3_count", int'(dseq_count), 2);
        send(0, 0, 0);
        chk("fill_reach_max", int'(hist_fill), 8);
        send(0, 0, 0);
        chk("fill_saturate", int'(hist_fill), 8);

        // T5 illegal lengths keep old config; clear+match yields 1
        clr();
        load(8'hFF, 4'd0, 1'b0);
        chk("t5_err_len0", int'(cfg_err), 1);
        chk("t5_fill_kept", int'(hist_fill), 8);
        tick();
        chk("t5_err_clears", int'(cfg_err), 0);
        load(8'hFF, 4'd9, 1'b0);
        chk("t5_err_len9", int'(cfg_err), 1);
        send(1, 0, 0); send(0, 0, 0); send(1, 0, 0); send(1, 1, 1);
        send(0, 0, 0); send(1, 0, 0); send(1, 1, 2);
        send(0, 0, 0); send(1, 0, 0);
        clear_count = 1'b1;
        send(1, 1, 1);
        tick();
        chk("t5_clear_match", int'(dseq_count), 1);

        // Load with in_valid in same cycle drops the bit
        in_valid = 1'b1; in_bit = 1'b1;
        load(8'b00001011, 4'd4, 1'b1);
        in_valid = 1'b0;
        chk("load_drops_bit_fill", int'(hist_fill), 0);
        tick();
        chk("load_no_pulse_count", int'(dseq_count), 1);

        // T4 saturating counter on CNT_W=4 instance
        b_cfg_load = 1; b_cfg_pattern = 8'h01; b_cfg_len = 4'd1; b_cfg_overlap = 1;
        tick();
        b_cfg_load = 0;
        b_in_valid = 1; b_in_bit = 1;
        repeat (15) tick();
        tick();
        b_in_valid = 0;
        chk("t4_count_15", int'(b_count), 15);
        b_in_valid = 1;
        repeat (4) tick();
        b_in_valid = 0;
        tick();
        chk("t4_saturate", int'(b_count), 15);
        b_clear = 1;
        tick();
        b_clear = 0;
        chk("t4_clear", int'(b_count), 0);

        // T6 reset mid-pattern
        send(1, 0, 0); send(0, 0, 0); send(1, 0, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t6_det", int'(seq_detected), 0);
        chk("t6_count", int'(dseq_count), 0);
        chk("t6_err", int'(cfg_err), 0);
        chk("t6_fill", int'(hist_fill), 0);
        send(1, 0, 0);
        tick(); tick();
        chk("t6_fill_after", int'(hist_fill), 1);
        chk("t6_count_after", int'(dseq_count), 0);

        repeat (3) tick();
        chk("queue_drained", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, %0d of %0d passed", n_pass, n_checks);
        $fatal(1);
    end

endmodule
